// File: rtl/xadc_drp_responder.sv
// XADC DRP responder: a two-channel conversion sequencer (voltage, then current)
// fed from AXI-Stream samples, with a fixed-latency DRP register port.
module xadc_drp_responder #(
  parameter logic [6:0] VOLTAGE_ADDR = 7'h14,
  parameter logic [6:0] CURRENT_ADDR = 7'h1C,
  parameter logic [6:0] CFG_ADDR     = 7'h41,
  parameter int         CONV_CYCLES  = 26,
  parameter int         DRP_LATENCY  = 2,
  parameter int         SEQ_GAP      = 4
) (
  input  logic        xadc_dclk,
  input  logic        xadc_reset_n,
  input  logic [6:0]  xadc_daddr,
  input  logic        xadc_den,
  input  logic        xadc_dwe,
  input  logic [15:0] xadc_di,
  output logic        xadc_drdy,
  output logic [15:0] xadc_do,
  output logic        xadc_eoc,
  output logic        xadc_eos,
  output logic        xadc_busy,
  output logic [4:0]  xadc_channel,
  input  logic [15:0] voltage_tdata,
  input  logic        voltage_tvalid,
  output logic        voltage_tready,
  input  logic [15:0] current_tdata,
  input  logic        current_tvalid,
  output logic        current_tready
);

  localparam logic [1:0] S_GAP    = 2'd0;
  localparam logic [1:0] S_CONV_V = 2'd1;
  localparam logic [1:0] S_CONV_I = 2'd2;

  localparam logic [7:0] CONV_LAST = 8'(CONV_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = (SEQ_GAP == 0) ? 8'd0 : 8'(SEQ_GAP - 1);
  localparam logic [3:0] LAT       = 4'(DRP_LATENCY);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] pend_v_q, pend_i_q, res_v_q, res_i_q, cfg_q;
  logic        eoc_q, eos_q;
  logic [4:0]  chan_q;
  logic        outst_q;
  logic [3:0]  lat_q;
  logic [15:0] rdata_q;

  logic        hold, conv_last, accept, drdy_w;
  logic [15:0] rd_mux;

  assign hold      = cfg_q[0];
  assign conv_last = (state_q != S_GAP) && (cnt_q == CONV_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    case (state_q)
      S_GAP: begin
        // Hold keeps the gap counter parked so a full gap follows its release.
        if (hold) begin
          cnt_d = 8'd0;
        end else if (SEQ_GAP == 0 || cnt_q == GAP_LAST) begin
          state_d = S_CONV_V;
          cnt_d   = 8'd0;
        end
      end
      S_CONV_V: begin
        if (conv_last) begin
          state_d = S_CONV_I;
          cnt_d   = 8'd0;
        end
      end
      S_CONV_I: begin
        if (conv_last) begin
          state_d = (SEQ_GAP == 0 && !hold) ? S_CONV_V : S_GAP;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = S_GAP;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign xadc_busy      = (state_q != S_GAP);
  assign voltage_tready = (state_q == S_CONV_V) && (cnt_q == 8'd0);
  assign current_tready = (state_q == S_CONV_I) && (cnt_q == 8'd0);
  assign xadc_eoc       = eoc_q;
  assign xadc_eos       = eos_q;
  assign xadc_channel   = chan_q;

  always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
    if (!xadc_reset_n) begin
      state_q  <= S_GAP;
      cnt_q    <= 8'd0;
      pend_v_q <= 16'h0000;
      pend_i_q <= 16'h0000;
      res_v_q  <= 16'h0000;
      res_i_q  <= 16'h0000;
      eoc_q    <= 1'b0;
      eos_q    <= 1'b0;
      chan_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (voltage_tready && voltage_tvalid) pend_v_q <= voltage_tdata;
      if (current_tready && current_tvalid) pend_i_q <= current_tdata;
      eoc_q <= conv_last;
      eos_q <= conv_last && (state_q == S_CONV_I);
      if (conv_last) begin
        if (state_q == S_CONV_V) begin
          res_v_q <= pend_v_q;
          chan_q  <= VOLTAGE_ADDR[4:0];
        end else begin
          res_i_q <= pend_i_q;
          chan_q  <= CURRENT_ADDR[4:0];
        end
      end
    end
  end

  // Read data is captured at accept, so a same-edge result update is not visible.
  always_comb begin
    rd_mux = 16'h0000;
    if (xadc_daddr == VOLTAGE_ADDR)      rd_mux = res_v_q;
    else if (xadc_daddr == CURRENT_ADDR) rd_mux = res_i_q;
    else if (xadc_daddr == CFG_ADDR)     rd_mux = cfg_q;
  end

  assign accept    = xadc_den && !outst_q;
  assign drdy_w    = outst_q && (lat_q == LAT);
  assign xadc_drdy = drdy_w;
  assign xadc_do   = drdy_w ? rdata_q : 16'h0000;

  always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
    if (!xadc_reset_n) begin
      outst_q <= 1'b0;
      lat_q   <= 4'd0;
      rdata_q <= 16'h0000;
      cfg_q   <= 16'h0000;
    end else if (accept) begin
      outst_q <= 1'b1;
      lat_q   <= 4'd1;
      rdata_q <= xadc_dwe ? 16'h0000 : rd_mux;
      if (xadc_dwe && xadc_daddr == CFG_ADDR) cfg_q <= xadc_di;
    end else if (outst_q) begin
      // The request stays outstanding through its drdy cycle.
      if (drdy_w) outst_q <= 1'b0;
      else        lat_q   <= lat_q + 4'd1;
    end
  end

endmodule

// File: doc/xadc_drp_responder.md
XADC_DRP_RESPONDER -- requirements
Module: xadc_drp_responder

Interface
REQ-001 SHALL have parameter VOLTAGE_ADDR, default 7'h14, DRP address and channel code of the voltage result register.
REQ-002 SHALL have parameter CURRENT_ADDR, default 7'h1C, DRP address and channel code of the current result register.
REQ-003 SHALL have parameter CFG_ADDR, default 7'h41, DRP address of the writable config register.
REQ-004 SHALL have parameter CONV_CYCLES, default 26 (legal 2..255), busy cycles per conversion.
REQ-005 SHALL have parameter DRP_LATENCY, default 2 (legal 1..15), cycles from accepted den to drdy.
REQ-006 SHALL have parameter SEQ_GAP, default 4 (legal 0..255), idle cycles between sequences.
REQ-007 SHALL have port xadc_dclk  in  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have port xadc_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-009 SHALL have ports xadc_daddr  in  7, xadc_den  in  1, xadc_dwe  in  1, xadc_di  in  16: DRP request.
REQ-010 SHALL have ports xadc_drdy  out  1, xadc_do  out  16: DRP response.
REQ-011 SHALL have ports xadc_eoc  out  1, xadc_eos  out  1, xadc_busy  out  1, xadc_channel  out  5: conversion status.
REQ-012 SHALL have ports voltage_tdata  in  16, voltage_tvalid  in  1, voltage_tready  out  1: AXI-Stream sink for voltage samples.
REQ-013 SHALL have ports current_tdata  in  16, current_tvalid  in  1, current_tready  out  1: AXI-Stream sink for current samples.

Function
REQ-014 Sequencer SHALL be a state machine with states GAP, CONV_V, CONV_I; GAP lasts SEQ_GAP cycles (0 = skipped), CONV_V and CONV_I each last exactly CONV_CYCLES cycles.
REQ-015 Transitions SHALL be GAP->CONV_V, CONV_V->CONV_I, CONV_I->GAP; GAP SHALL hold while cfg[0]=1 (hold); a set hold never aborts a running conversion.
REQ-016 xadc_busy SHALL be 1 in CONV_V/CONV_I, 0 in GAP.
REQ-017 voltage_tready SHALL be 1 only in the first cycle of CONV_V, current_tready only in the first cycle of CONV_I; if tvalid is high that cycle, tdata SHALL be latched as pending sample, else the previous pending sample SHALL be reused.
REQ-018 On the last cycle of a conversion, the pending sample SHALL be written to the result register on the next edge, and xadc_eoc SHALL pulse for exactly one cycle with xadc_channel = low 5 bits of that register's address.
REQ-019 The eoc ending CONV_I SHALL coincide with a one-cycle xadc_eos pulse; xadc_channel SHALL hold its last value between pulses.
REQ-020 A DRP request SHALL be accepted when xadc_den=1 and no request is outstanding; den while outstanding SHALL be ignored (no second drdy).
REQ-021 Read (dwe=0): xadc_do SHALL present the addressed register's value as sampled in the accept cycle, with xadc_drdy high exactly DRP_LATENCY cycles after accept for one cycle.
REQ-022 Simultaneous result update and read accept SHALL return the pre-update value.
REQ-023 Write (dwe=1) to CFG_ADDR SHALL store xadc_di; writes to any other address SHALL be discarded; both SHALL produce drdy with xadc_do = 0.
REQ-024 Reads of CFG_ADDR SHALL return cfg; reads of unmapped addresses SHALL return 16'h0000.
REQ-025 xadc_do SHALL be 0 whenever xadc_drdy is 0.
REQ-026 A new request SHALL be accepted in the cycle immediately after drdy (back-to-back throughput of DRP_LATENCY+1 cycles).

Reset
REQ-027 While xadc_reset_n=0: all outputs 0, both result registers, pending samples and cfg 16'h0000, outstanding request cleared, state GAP with counter at 0.
REQ-028 Reset asserted mid-conversion or with a request outstanding SHALL cancel it; no eoc/eos/drdy SHALL appear for it after release.
REQ-029 After release, the first CONV_V SHALL start SEQ_GAP cycles later.

Verification
REQ-030 Defaults, voltage_tdata=16'hA5A0 and current_tdata=16'h1230 held valid -> eoc(channel 5'h14) then eoc+eos(channel 5'h1C) 26 cycles apart; reads of 7'h14/7'h1C return 16'hA5A0/16'h1230 with drdy 2 cycles after den.
REQ-031 Current tvalid=0 in second sequence -> read of 7'h1C still 16'h1230; first sequence without valid -> 16'h0000.
REQ-032 Write 16'h0001 to 7'h41 mid-CONV_V -> that sequence completes with eos, then busy stays 0; read 7'h41 -> 16'h0001; write 16'h0000 -> CONV_V starts after GAP.
REQ-033 den held high 5 cycles -> exactly one drdy; den in the cycle after drdy -> accepted; read of 7'h00 -> 16'h0000.
REQ-034 Read of 7'h14 accepted in the same cycle as voltage result update -> old value returned.
REQ-035 Reset pulse one cycle after den and mid-CONV_I -> no drdy, no eos; all outputs 0; first busy after SEQ_GAP cycles.
